msg_player: RTL

Parametrised message source that holds up to DEPTH stimulus messages in a writable buffer and plays them into the downstream `sequencer`/`processor` path over a valid/ready handshake. It is the successor to the fixed five-entry, button-stepped message ROM: it adds a runtime load port, a programmable play length, a free-running mode with a cycle interval, loop-or-stop at end of list, an abort, and status outputs.

---
 rtl/msg_player.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/msg_player.sv
// rtl/msg_player.sv - buffered stimulus message player with valid/ready output
//
// Holds DEPTH messages of MSG_W bits in a runtime-writable buffer and plays the
// first len of them downstream, one message per trigger. A trigger is either a
// rising edge on next_msg (step mode) or an elapsed interval of period cycles
// (run mode). At the end of the list the player wraps (loop_en) or parks in DONE.
//
// Optional feature macro: MSG_PLAYER_DEBOUNCE_EN
//   defined   : next_msg is synchronised (2 flops) and debounced over
//               DEBOUNCE_CYCLES stable cycles before edge detection.
//   undefined : next_msg is taken as a synchronous level.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   wr_en      in   load-port write strobe (any state)
//   wr_addr    in   load-port entry index
//   wr_data    in   load-port data
//   len        in   entries to play, 1..DEPTH (larger clamps, 0 ignored); latched on start
//   mode       in   0 = step, 1 = run; latched on start
//   loop_en    in   wrap to entry 0 after the last entry; latched on start
//   period     in   run-mode interval in cycles; latched on start
//   start      in   begin/restart play from IDLE or DONE
//   abort      in   return to IDLE, withdraw msg_valid
//   next_msg   in   step trigger level (button)
//   msg_out    out  presented message, captured at trigger
//   msg_valid  out  msg_out is valid
//   msg_ready  in   downstream accepts msg_out
//   idx        out  buffer index of the entry currently or last presented
//   busy       out  high in ARM or SEND
//   done       out  high in DONE

module msg_player #(
   parameter int MSG_W           = 168,
   parameter int DEPTH           = 8,
   parameter int PERIOD_W        = 16,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [MSG_W-1:0]         wr_data,
   input  logic [$clog2(DEPTH):0]   len,
   input  logic                     mode,
   input  logic                     loop_en,
   input  logic [PERIOD_W-1:0]      period,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     next_msg,
   output logic [MSG_W-1:0]         msg_out,
   output logic                     msg_valid,
   input  logic                     msg_ready,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]         LEN_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0]         LEN_ONE = (AW+1)'(1);
   localparam logic [AW-1:0]       PTR_ONE = AW'(1);
   localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

   // Elaboration-time marker for configurations the player cannot honour.
   if (DEPTH < 2 || DEBOUNCE_CYCLES < 1) begin : g_invalid_parameters
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Message buffer (deliberately not reset; contents survive rst)
   // ------------------------------------------------------------------
   logic [MSG_W-1:0] r_buf [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_buf[wr_addr] <= wr_data;
      end
   end

   // ------------------------------------------------------------------
   // next_msg conditioning: r_next_lvl is the level seen by the edge
   // detector. Both variants register it once, so a rise sampled at
   // edge k triggers at edge k+1 in the plain build.
   // ------------------------------------------------------------------
   logic r_next_lvl;
   logic r_next_dly;
   logic w_rise;

`ifdef MSG_PLAYER_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);

   logic            r_sync1;
   logic            r_sync2;
   logic [DB_W-1:0] r_db_cnt;

   // The counter runs while the synchronised input disagrees with the
   // conditioned level and restarts on any bounce back; the level only
   // follows once the disagreement has lasted the full count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_db_cnt   <= '0;
         r_next_lvl <= 1'b0;
      end else begin
         r_sync1 <= next_msg;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_next_lvl) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LIMIT) begin
            r_next_lvl <= r_sync2;
            r_db_cnt   <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DB_ONE;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         r_next_lvl <= 1'b0;
      end else begin
         r_next_lvl <= next_msg;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_next_dly <= 1'b0;
      end else begin
         r_next_dly <= r_next_lvl;
      end
   end

   // Only consumed in ARM; rises elsewhere are simply lost.
   assign w_rise = r_next_lvl & ~r_next_dly;

   // ------------------------------------------------------------------
   // Play control
   // ------------------------------------------------------------------
   state_t               r_state;
   logic [AW-1:0]        r_ptr;
   logic [AW:0]          r_last;      // latched len-1 after clamping
   logic                 r_mode;
   logic                 r_loop;
   logic [PERIOD_W-1:0]  r_period;
   logic [PERIOD_W-1:0]  r_cnt;
   logic [MSG_W-1:0]     r_msg_out;
   logic                 r_msg_valid;
   logic [AW-1:0]        r_idx;
   logic                 r_busy;
   logic                 r_done;

   logic [AW:0]          w_len_clamp;
   logic [AW:0]          w_len_m1;
   logic                 w_start_ok;
   logic                 w_trigger;
   logic                 w_last;

   assign w_len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
   assign w_len_m1    = w_len_clamp - LEN_ONE;
   assign w_start_ok  = start && (len != '0);
   assign w_trigger   = r_mode ? (r_cnt == r_period) : w_rise;
   assign w_last      = ({1'b0, r_ptr} == r_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_last      <= '0;
         r_mode      <= 1'b0;
         r_loop      <= 1'b0;
         r_period    <= '0;
         r_cnt       <= '0;
         r_msg_out   <= '0;
         r_msg_valid <= 1'b0;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else if (abort) begin
         // msg_out and idx keep the last presented entry for observation.
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_msg_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  r_last   <= w_len_m1;
                  r_mode   <= mode;
                  r_loop   <= loop_en;
                  r_period <= period;
                  r_ptr    <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_ARM;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end

            S_ARM: begin
               if (w_trigger) begin
                  // Snapshot: later writes to this entry do not disturb msg_out.
                  r_msg_out   <= r_buf[r_ptr];
                  r_idx       <= r_ptr;
                  r_msg_valid <= 1'b1;
                  r_state     <= S_SEND;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            S_SEND: begin
               if (msg_ready) begin
                  r_msg_valid <= 1'b0;
                  r_cnt       <= '0;
                  if (w_last) begin
                     if (r_loop) begin
                        r_ptr   <= '0;
                        r_state <= S_ARM;
                     end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_ptr   <= r_ptr + PTR_ONE;
                     r_state <= S_ARM;
                  end
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_msg_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign msg_out   = r_msg_out;
   assign msg_valid = r_msg_valid;
   assign idx       = r_idx;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
